// File: rtl/debug_ctrl.sv
// Debug controller: run / single-step / cycle-step control of a DUT core,
// with a small breakpoint table, stop-reason reporting and retire counting.
// The "running" window is the RUN/STEPI/STEPC state; cpu_halt additionally
// rises combinationally in the cycle a terminating event is seen so the DUT
// freezes without a one-cycle overrun. Retire counting and exit detection
// follow the running window, so the retire that ends a STEPI is counted.
module debug_ctrl #(
  parameter  int ADDR_W = 32,
  parameter  int NUM_BP = 4,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] dut_pc,
  input  logic              instr_retired,
  input  logic              finish_exec,
  output logic              cpu_halt,
  output logic              cmd_done,
  output logic [2:0]        stop_reason,
  output logic [IDX_W-1:0]  bp_hit_idx,
  output logic              exit_signal,
  output logic [31:0]       retired_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEPI, S_STEPC} state_t;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEPI  = 3'd2;
  localparam logic [2:0] OP_STEPC  = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;

  localparam logic [2:0] RSN_NONE   = 3'd0;
  localparam logic [2:0] RSN_COUNT  = 3'd1;
  localparam logic [2:0] RSN_BP     = 3'd2;
  localparam logic [2:0] RSN_HALT   = 3'd3;
  localparam logic [2:0] RSN_FINISH = 3'd4;
  localparam logic [2:0] RSN_ERROR  = 3'd5;

  state_t                         r_state, w_next;
  logic [CNT_W-1:0]               r_rem;
  logic                           r_first;
  logic [NUM_BP-1:0]              r_bp_en;
  logic [NUM_BP-1:0][ADDR_W-1:0]  r_bp_addr;
  logic                           r_done;
  logic [2:0]                     r_reason;
  logic [IDX_W-1:0]               r_idx;
  logic                           r_exit;
  logic [31:0]                    r_cnt;

  logic                           w_active;
  logic                           w_accept;
  logic                           w_term;
  logic                           w_count_done;
  logic                           w_bp_match;
  logic [IDX_W-1:0]               w_bp_idx;
  logic                           w_bp_fire;
  logic                           w_slot_ok;
  logic [IDX_W-1:0]               w_slot;

  assign w_active  = (r_state != S_IDLE);
  // The first running cycle ignores matches so a resume from a breakpoint PC moves on.
  assign w_bp_fire = w_active && !r_first && w_bp_match;
  assign w_slot_ok = (cmd_arg < CNT_W'(NUM_BP));
  assign w_slot    = cmd_arg[IDX_W-1:0];

  assign cmd_done    = r_done;
  assign stop_reason = r_reason;
  assign bp_hit_idx  = r_idx;
  assign exit_signal = r_exit;
  assign retired_cnt = r_cnt;

  // Breakpoint compare: scan high to low so the lowest matching slot wins.
  always_comb begin
    w_bp_match = 1'b0;
    w_bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (r_bp_en[i] && (r_bp_addr[i] == dut_pc)) begin
        w_bp_match = 1'b1;
        w_bp_idx   = IDX_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, handshake, termination detect and freeze output.
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_term       = 1'b0;
    w_count_done = 1'b0;
    cmd_ready    = 1'b0;
    cpu_halt     = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        w_accept  = cmd_valid;
        // After end-of-program, run commands are acknowledged but never leave IDLE.
        if (cmd_valid && !r_exit) begin
          case (cmd_op)
            OP_RUN:   w_next = S_RUN;
            OP_STEPI: w_next = S_STEPI;
            OP_STEPC: w_next = S_STEPC;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_STEPI: w_count_done = instr_retired && (r_rem == CNT_W'(1));
      S_STEPC: w_count_done = (r_rem == CNT_W'(1));
      default: w_count_done = 1'b0;
    endcase
    if (w_active) begin
      w_term   = finish_exec || halt_req || w_bp_fire || w_count_done;
      cpu_halt = w_term;
      if (w_term) w_next = S_IDLE;
    end
  end

  // Datapath: breakpoint table, step counter, status and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_first   <= 1'b0;
      r_bp_en   <= '0;
      r_bp_addr <= '0;
      r_done    <= 1'b0;
      r_reason  <= RSN_NONE;
      r_idx     <= '0;
      r_exit    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_done  <= w_accept || w_term;
      r_first <= 1'b0;
      if (w_active) begin
        if (instr_retired) r_cnt <= r_cnt + 32'd1;
        if (finish_exec)   r_exit <= 1'b1;
        if (w_term) begin
          if (finish_exec)    r_reason <= RSN_FINISH;
          else if (halt_req)  r_reason <= RSN_HALT;
          else if (w_bp_fire) begin
            r_reason <= RSN_BP;
            r_idx    <= w_bp_idx;
          end else            r_reason <= RSN_COUNT;
        end else if ((r_state == S_STEPC) || ((r_state == S_STEPI) && instr_retired)) begin
          r_rem <= r_rem - 1'b1;
        end
      end
      if (w_accept) begin
        r_idx <= '0;
        case (cmd_op)
          OP_RUN, OP_STEPI, OP_STEPC: begin
            if (r_exit) r_reason <= RSN_FINISH;
            else begin
              r_reason <= RSN_NONE;
              r_rem    <= (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
              r_first  <= 1'b1;
            end
          end
          OP_SET_BP, OP_CLR_BP: begin
            if (w_slot_ok) begin
              r_reason         <= RSN_NONE;
              r_bp_en[w_slot]  <= (cmd_op == OP_SET_BP);
              if (cmd_op == OP_SET_BP) r_bp_addr[w_slot] <= cmd_addr;
            end else begin
              r_reason <= RSN_ERROR;
            end
          end
          default: r_reason <= RSN_ERROR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_debug_ctrl;
  localparam int ADDR_W = 32;
  localparam int NUM_BP = 4;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [CNT_W-1:0]  cmd_arg;
  logic [ADDR_W-1:0] cmd_addr;
  logic              halt_req;
  logic [ADDR_W-1:0] dut_pc;
  logic              instr_retired;
  logic              finish_exec;
  logic              cpu_halt;
  logic              cmd_done;
  logic [2:0]        stop_reason;
  logic [IDX_W-1:0]  bp_hit_idx;
  logic              exit_signal;
  logic [31:0]       retired_cnt;

  always #5 clk = ~clk;

  debug_ctrl #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_addr(cmd_addr), .halt_req(halt_req),
    .dut_pc(dut_pc), .instr_retired(instr_retired), .finish_exec(finish_exec),
    .cpu_halt(cpu_halt), .cmd_done(cmd_done), .stop_reason(stop_reason),
    .bp_hit_idx(bp_hit_idx), .exit_signal(exit_signal), .retired_cnt(retired_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mode 0 = idle, otherwise the opcode of the running command.
  int                m_mode;
  int                m_rem;
  bit                m_fresh;
  bit                m_en[NUM_BP];
  logic [ADDR_W-1:0] m_addr[NUM_BP];
  int                m_reason;
  int                m_idx;
  bit                m_done;
  bit                m_exit;
  logic [31:0]       m_cnt;
  bit                e_hit;
  int                e_hidx;
  bit                e_term;
  bit                e_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_rem = 0; m_fresh = 0; m_reason = 0; m_idx = 0;
    m_done = 0; m_exit = 0; m_cnt = 0;
    for (int i = 0; i < NUM_BP; i++) begin m_en[i] = 0; m_addr[i] = '0; end
  endfunction

  function automatic void model_eval();
    e_hit = 0; e_hidx = 0;
    if (m_mode != 0 && !m_fresh)
      for (int i = 0; i < NUM_BP; i++)
        if (!e_hit && m_en[i] && m_addr[i] == dut_pc) begin e_hit = 1; e_hidx = i; end
    e_term = (m_mode != 0) && (finish_exec || halt_req || e_hit ||
             (m_mode == 2 && instr_retired && m_rem == 1) || (m_mode == 3 && m_rem == 1));
    e_halt = (m_mode == 0) || e_term;
  endfunction

  function automatic void model_step();
    int a;
    if (reset) begin model_reset(); return; end
    m_done = 0;
    a = int'(cmd_arg);
    if (m_mode != 0) begin
      if (instr_retired) m_cnt = m_cnt + 1;
      if (finish_exec) m_exit = 1;
      if (e_term) begin
        m_done = 1;
        m_mode = 0;
        m_reason = finish_exec ? 4 : halt_req ? 3 : e_hit ? 2 : 1;
        if (m_reason == 2) m_idx = e_hidx;
      end else if (m_mode == 3 || (m_mode == 2 && instr_retired)) begin
        m_rem--;
      end
      m_fresh = 0;
    end else if (cmd_valid) begin
      m_done = 1;
      m_idx = 0;
      if (cmd_op inside {3'd1, 3'd2, 3'd3}) begin
        if (m_exit) m_reason = 4;
        else begin
          m_mode = int'(cmd_op); m_rem = (a == 0) ? 1 : a; m_fresh = 1; m_reason = 0;
        end
      end else if (cmd_op inside {3'd4, 3'd5} && a < NUM_BP) begin
        m_en[a] = (cmd_op == 3'd4);
        if (cmd_op == 3'd4) m_addr[a] = cmd_addr;
        m_reason = 0;
      end else begin
        m_reason = 5;
      end
    end
  endfunction

  task automatic settle();
    #1;
    model_eval();
    check("cpu_halt", 32'(cpu_halt), 32'(e_halt));
    check("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
    check("cmd_done", 32'(cmd_done), 32'(m_done));
    check("stop_reason", 32'(stop_reason), 32'(m_reason));
    check("exit_signal", 32'(exit_signal), 32'(m_exit));
    check("retired_cnt", retired_cnt, m_cnt);
    if (m_reason == 2) check("bp_hit_idx", 32'(bp_hit_idx), 32'(m_idx));
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    advance();
  endtask

  task automatic quiet();
    reset = 0; cmd_valid = 0; cmd_op = '0; cmd_arg = '0; cmd_addr = '0;
    halt_req = 0; instr_retired = 0; finish_exec = 0;
  endtask

  task automatic send(input int op, input int arg, input logic [ADDR_W-1:0] addr);
    cmd_valid = 1; cmd_op = op[2:0]; cmd_arg = arg[CNT_W-1:0]; cmd_addr = addr;
    cyc();
    cmd_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    quiet();
    dut_pc = 32'h1000;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    settle();
    check("rst_cpu_halt", 32'(cpu_halt), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    advance();

    // STEPI 3 with a retire every second cycle.
    send(2, 3, '0);
    for (int k = 0; k < 6; k++) begin
      instr_retired = (k % 2 == 1);
      settle();
      if (k == 5) check("stepi_halt_on_3rd", 32'(cpu_halt), 32'd1);
      advance();
    end
    instr_retired = 0;
    settle();
    check("stepi_done", 32'(cmd_done), 32'd1);
    check("stepi_reason", 32'(stop_reason), 32'd1);
    check("stepi_cnt", retired_cnt, 32'd3);
    advance();

    // Breakpoint in slot 2, hit, then resume from the same PC.
    send(4, 2, 32'h40);
    cyc();
    send(1, 0, '0);
    dut_pc = 32'h10; cyc();
    dut_pc = 32'h20; cyc();
    dut_pc = 32'h40;
    settle();
    check("bp_halt", 32'(cpu_halt), 32'd1);
    advance();
    settle();
    check("bp_reason", 32'(stop_reason), 32'd2);
    check("bp_idx", 32'(bp_hit_idx), 32'd2);
    advance();
    send(1, 0, '0);
    settle();
    check("bp_resume_runs", 32'(cpu_halt), 32'd0);
    advance();
    cyc();
    cyc();

    // STEPC 0 behaves as a single cycle step.
    dut_pc = 32'h1000;
    send(3, 0, '0);
    settle();
    check("stepc0_active", 32'(cmd_ready), 32'd0);
    advance();
    settle();
    check("stepc0_done", 32'(cmd_done), 32'd1);
    check("stepc0_reason", 32'(stop_reason), 32'd1);
    advance();

    // Reset in the middle of a long STEPC.
    send(3, 100, '0);
    reset = 1; instr_retired = 1;
    cyc();
    reset = 0; instr_retired = 0;
    settle();
    check("mrst_idle", 32'(cmd_ready), 32'd1);
    check("mrst_halt", 32'(cpu_halt), 32'd1);
    check("mrst_exit", 32'(exit_signal), 32'd0);
    check("mrst_cnt", retired_cnt, 32'd0);
    check("mrst_done", 32'(cmd_done), 32'd0);
    advance();

    // Out-of-range slot and illegal opcode leave the table alone.
    send(4, 1, 32'h80);
    cyc();
    send(4, NUM_BP, 32'h90);
    settle();
    check("badslot_done", 32'(cmd_done), 32'd1);
    check("badslot_reason", 32'(stop_reason), 32'd5);
    advance();
    send(7, 0, 32'h80);
    settle();
    check("illop_done", 32'(cmd_done), 32'd1);
    check("illop_reason", 32'(stop_reason), 32'd5);
    advance();
    send(1, 0, '0);
    dut_pc = 32'h90; cyc(); cyc();
    dut_pc = 32'h80;
    settle();
    check("table_kept_halt", 32'(cpu_halt), 32'd1);
    advance();
    settle();
    check("table_kept_idx", 32'(bp_hit_idx), 32'd1);
    advance();

    // Finish, halt_req and breakpoint together; then a step after exit.
    dut_pc = 32'h1000;
    send(1, 0, '0);
    cyc();
    dut_pc = 32'h80; halt_req = 1; finish_exec = 1;
    settle();
    check("combo_halt", 32'(cpu_halt), 32'd1);
    advance();
    quiet();
    settle();
    check("combo_reason", 32'(stop_reason), 32'd4);
    check("combo_exit", 32'(exit_signal), 32'd1);
    advance();
    send(2, 2, '0);
    settle();
    check("postexit_halt", 32'(cpu_halt), 32'd1);
    check("postexit_idle", 32'(cmd_ready), 32'd1);
    check("postexit_done", 32'(cmd_done), 32'd1);
    check("postexit_reason", 32'(stop_reason), 32'd4);
    advance();
    reset = 1;
    cyc();
    reset = 0;
    settle();
    check("exit_cleared", 32'(exit_signal), 32'd0);
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      cmd_valid     = ($urandom_range(0, 2) == 0);
      cmd_op        = 3'($urandom_range(0, 7));
      cmd_arg       = (cmd_op >= 3'd4) ? CNT_W'($urandom_range(0, 5)) : CNT_W'($urandom_range(0, 6));
      cmd_addr      = 32'h40 + 32'(4 * $urandom_range(0, 3));
      dut_pc        = 32'h40 + 32'(4 * $urandom_range(0, 3));
      halt_req      = ($urandom_range(0, 24) == 0);
      instr_retired = ($urandom_range(0, 1) == 1);
      finish_exec   = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
